pc_fetch_ctrl: RTL and testbench

//  Sequences the CPU program counter and the instruction-memory fetch handshake.

---
 rtl/pc_fetch_ctrl_if.sv | 41 ++++
 rtl/pc_fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: decode/branch redirects, instruction-memory handshake and IF/ID qualifiers.
// With PC_EXC_EN defined, the exception request and saved EPC are also carried.
interface pc_fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] fetch_pc;
  logic             instr_valid;
`ifdef PC_EXC_EN
  logic             exc;
  logic [WIDTH-1:0] epc;
`endif

`ifdef PC_EXC_EN
  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, imem_ack, exc,
    output imem_req, imem_addr, pc, fetch_pc, instr_valid, epc
  );
  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, imem_ack, exc,
    input  imem_req, imem_addr, pc, fetch_pc, instr_valid, epc
  );
`else
  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, imem_ack,
    output imem_req, imem_addr, pc, fetch_pc, instr_valid
  );
  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, imem_ack,
    input  imem_req, imem_addr, pc, fetch_pc, instr_valid
  );
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer and instruction-fetch handshake (IDLE/FETCH/DRAIN/HOLD).
// Optional exception redirect and EPC capture are enabled by defining PC_EXC_EN.
module pc_fetch_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000
`ifdef PC_EXC_EN
  ,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180
`endif
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic [WIDTH-1:0] fpc_q, fpc_nxt;
  logic             vld_q, vld_nxt;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_nxt;
  logic [1:0]       pend_prio_q, pend_prio_nxt;
  logic [WIDTH-1:0] epc_q, epc_nxt;

  logic             redir;
  logic [WIDTH-1:0] redir_tgt;
  logic [1:0]       redir_prio;
  logic             take_new;
  logic [WIDTH-1:0] merged_tgt;
  logic [1:0]       merged_prio;

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return a & ~WIDTH'(3);
  endfunction

  // Redirect select; later assignments win, giving exc > jmp > br_taken.
  always_comb begin
    redir      = 1'b0;
    redir_tgt  = '0;
    redir_prio = 2'd0;
    if (bus.br_taken) begin
      redir      = 1'b1;
      redir_tgt  = word_align(bus.br_target);
      redir_prio = 2'd1;
    end
    if (bus.jmp) begin
      redir      = 1'b1;
      redir_tgt  = word_align(bus.jmp_target);
      redir_prio = 2'd2;
    end
`ifdef PC_EXC_EN
    if (bus.exc) begin
      redir      = 1'b1;
      redir_tgt  = word_align(EXC_VEC);
      redir_prio = 2'd3;
    end
`endif
  end

  // A newer redirect replaces the stored one unless the stored one outranks it.
  always_comb begin
    take_new    = redir && (redir_prio >= pend_prio_q);
    merged_tgt  = take_new ? redir_tgt  : pend_tgt_q;
    merged_prio = take_new ? redir_prio : pend_prio_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    fpc_nxt       = fpc_q;
    vld_nxt       = 1'b0;
    pend_tgt_nxt  = pend_tgt_q;
    pend_prio_nxt = pend_prio_q;
    epc_nxt       = epc_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          if (redir) begin
            pc_nxt = redir_tgt;
          end else begin
            pc_nxt  = pc_q + WIDTH'(4);
            fpc_nxt = pc_q;
            vld_nxt = 1'b1;
          end
          state_nxt = bus.stall ? HOLD : FETCH;
        end else if (redir) begin
          pend_tgt_nxt  = redir_tgt;
          pend_prio_nxt = redir_prio;
          state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        pend_tgt_nxt  = merged_tgt;
        pend_prio_nxt = merged_prio;
        if (bus.imem_ack) begin
          pc_nxt        = merged_tgt;
          pend_prio_nxt = 2'd0;
          state_nxt     = bus.stall ? HOLD : FETCH;
        end
      end
      HOLD: begin
        if (redir) pc_nxt = redir_tgt;
        if (!bus.stall) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PC_EXC_EN
    // pc is still the in-flight address here, also in DRAIN.
    if (bus.exc && (state != IDLE)) epc_nxt = pc_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VEC;
      fpc_q       <= RESET_VEC;
      vld_q       <= 1'b0;
      pend_tgt_q  <= '0;
      pend_prio_q <= 2'd0;
      epc_q       <= '0;
    end else begin
      pc_q        <= pc_nxt;
      fpc_q       <= fpc_nxt;
      vld_q       <= vld_nxt;
      pend_tgt_q  <= pend_tgt_nxt;
      pend_prio_q <= pend_prio_nxt;
      epc_q       <= epc_nxt;
    end
  end

  assign bus.imem_req    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_pc    = fpc_q;
  assign bus.instr_valid = vld_q;
`ifdef PC_EXC_EN
  assign bus.epc         = epc_q;
`else
  logic unused_epc;
  assign unused_epc = ^epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a transaction-level reference model and per-cycle compare.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] EV = 32'h0000_4180;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_fetch_ctrl_if #(.WIDTH(32)) bus ();
  pc_fetch_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is either outstanding (req) or not; an outstanding
  // fetch may already be doomed by a redirect, whose best target is remembered.
  bit          m_started, m_req, m_vld, m_doomed;
  logic [31:0] m_pc, m_fpc, m_tgt, m_epc;
  int          m_rank;

  always @(posedge clk or negedge rst) begin
    logic        r, e_in;
    logic [31:0] t, pc_before;
    int          p;
    if (!rst) begin
      m_started = 0; m_req = 0; m_vld = 0; m_doomed = 0;
      m_pc = RV; m_fpc = RV; m_tgt = 0; m_rank = 0; m_epc = 0;
    end else if (!m_started) begin
      m_started = 1; m_req = 1; m_vld = 0;
    end else begin
`ifdef PC_EXC_EN
      e_in = bus.exc;
`else
      e_in = 1'b0;
`endif
      r = 0; t = 0; p = 0; m_vld = 0; pc_before = m_pc;
      if (bus.br_taken) begin r = 1; t = bus.br_target & ~32'h3; p = 1; end
      if (bus.jmp)      begin r = 1; t = bus.jmp_target & ~32'h3; p = 2; end
      if (e_in)         begin r = 1; t = EV; p = 3; end
      if (m_req) begin
        if (m_doomed && r && p >= m_rank) begin m_tgt = t; m_rank = p; end
        if (bus.imem_ack) begin
          if (m_doomed) m_pc = m_tgt;
          else if (r) m_pc = t;
          else begin m_fpc = m_pc; m_pc = m_pc + 32'd4; m_vld = 1; end
          m_doomed = 0; m_rank = 0; m_req = !bus.stall;
        end else if (r && !m_doomed) begin
          m_doomed = 1; m_tgt = t; m_rank = p;
        end
      end else begin
        if (r) m_pc = t;
        if (!bus.stall) m_req = 1;
      end
      if (e_in) m_epc = pc_before;
    end
  end

  always @(negedge clk) begin
    chk("model imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
    chk("model imem_addr", bus.imem_addr, m_pc);
    chk("model pc", bus.pc, m_pc);
    chk("model fetch_pc", bus.fetch_pc, m_fpc);
    chk("model instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_vld});
`ifdef PC_EXC_EN
    chk("model epc", bus.epc, m_epc);
`endif
  end

  task automatic cyc(input logic a, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic e);
    @(negedge clk);
    bus.imem_ack = a; bus.stall = s;
    bus.br_taken = b; bus.br_target = bt;
    bus.jmp = j; bus.jmp_target = jt;
`ifdef PC_EXC_EN
    bus.exc = e;
`else
    if (e) $display("note: exc request ignored in this build");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    bus.imem_ack = 0; bus.stall = 0; bus.br_taken = 0; bus.br_target = 0;
    bus.jmp = 0; bus.jmp_target = 0;
`ifdef PC_EXC_EN
    bus.exc = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("reset pc", bus.pc, 32'h3000);
    chk("reset fetch_pc", bus.fetch_pc, 32'h3000);
    chk("reset instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    rst = 1'b1;

    // Four zero-wait fetches
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("t1 imem_addr", bus.imem_addr, 32'h3000 + 32'(4 * i));
      if (i > 0) begin
        chk("t1 instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t1 fetch_pc", bus.fetch_pc, 32'h3000 + 32'(4 * (i - 1)));
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1 last fetch_pc", bus.fetch_pc, 32'h300C);
    chk("t1 pc", bus.pc, 32'h3010);

    // Branch during the second wait cycle drains the in-flight fetch
    cyc(0, 0, 1, 32'h3401, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("t2 drain addr", bus.imem_addr, 32'h3010);
    chk("t2 drain req", {31'd0, bus.imem_req}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t2 squashed valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("t2 new addr", bus.imem_addr, 32'h3400);

    // Pending jmp outranks a later branch while draining
    cyc(0, 0, 0, 0, 1, 32'h3500, 0);
    cyc(0, 0, 1, 32'h3600, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h3000, 0);
    chk("drain priority", bus.imem_addr, 32'h3500);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Stall at the ack for 0x3000 held five cycles
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("t3 ack addr", bus.imem_addr, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("t3 req low", {31'd0, bus.imem_req}, 32'd0);
      chk("t3 pc held", bus.pc, 32'h3004);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t3 req low last", {31'd0, bus.imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t3 resume req", {31'd0, bus.imem_req}, 32'd1);
    chk("t3 resume addr", bus.imem_addr, 32'h3004);

    // Redirect while held loads pc at once
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3700, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold redirect pc", bus.pc, 32'h3700);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold redirect req", {31'd0, bus.imem_req}, 32'd1);

    // jmp beats br_taken on an ack cycle; the fetch is squashed
    cyc(1, 0, 1, 32'h3900, 1, 32'h3800, 0);
    chk("t4 ack addr", bus.imem_addr, 32'h3700);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4 next addr", bus.imem_addr, 32'h3800);
    chk("t4 no valid", {31'd0, bus.instr_valid}, 32'd0);

    // PC wrap from all-ones-minus-3
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap pc", bus.pc, 32'h0000_0000);
    chk("wrap fetch_pc", bus.fetch_pc, 32'hFFFF_FFFC);

    // Asynchronous reset mid-fetch at 0x3020
    cyc(0, 0, 0, 0, 1, 32'h3020, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t5 pre req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5 pre addr", bus.imem_addr, 32'h3020);
    #2 rst = 1'b0; bus.imem_ack = 1'b1;
    #1;
    chk("t5 rst req", {31'd0, bus.imem_req}, 32'd0);
    chk("t5 rst pc", bus.pc, 32'h3000);
    chk("t5 rst fetch_pc", bus.fetch_pc, 32'h3000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t5 first addr", bus.imem_addr, 32'h3000);
    chk("t5 first req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5 stale ack", {31'd0, bus.instr_valid}, 32'd0);

`ifdef PC_EXC_EN
    // Exception while fetching 0x3040
    cyc(0, 0, 0, 0, 1, 32'h3040, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t6 fetch addr", bus.imem_addr, 32'h3040);
    cyc(1, 0, 0, 0, 1, 32'h3100, 0);
    chk("t6 epc", bus.epc, 32'h3040);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t6 vector", bus.imem_addr, 32'h4180);
    chk("t6 no valid", {31'd0, bus.instr_valid}, 32'd0);
`endif

    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
